aload_sequencer: RTL
====================

# aload_sequencer

Control stage that drives the async-load pins (`arst`/`rval`) of a bank of emulated async-load flip-flops. It turns clocked load requests into a clean, glitch-free, minimum-width async-load pulse, with the load value set up before the pulse and held after it. On global reset it forces a load of a compile-time default value, then releases that load synchronously to `clk`. It sits directly upstream of the async-load register bank; in verify builds it also reads the bank's outputs back.

## Interface
- `WIDTH`, default 8: load-value width.
- `RESET_VALUE`, default `'0`: value loaded during global reset.
- `PULSE_CYCLES`, default 2: async-load pulse width in clk cycles; must be ≥1.
- `SYNC_STAGES`, default 2: reset-release synchronizer depth; must be ≥2.

Ports:
- `clk`  in  1  clock.
- `arst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  load request.
- `req_ready`  out  1  high only in IDLE.
- `req_value`  in  WIDTH  value to load; captured on accept.
- `aload_out`  out  1  to the bank's async-load input; registered, glitch-free.
- `aload_val`  out  WIDTH  to the bank's load-value input.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at completion.
- `q_in`  in  WIDTH  bank readback; ignored unless the verify macro is defined.
- `mismatch`  out  1  one-cycle readback-error flag; tied 0 unless the verify macro is defined.

## Operation
- States: RST_HOLD, IDLE, SETUP, PULSE, HOLD.
- While `arst`=1 (asynchronous):
  - `aload_out`=1, `aload_val`=RESET_VALUE, state=RST_HOLD.
  - Synchronizer cleared, pulse counter cleared.
  - `req_ready`=0, `busy`=1, `done`=0, `mismatch`=0.
- RST_HOLD→IDLE: on the SYNC_STAGES-th rising edge after `arst` falls. `aload_out` falls at that same edge.
- IDLE: `req_ready`=1, `aload_out`=0, `aload_val` holds the last loaded value.
  - On `req_valid`&&`req_ready` at edge E0: capture `req_value` into `aload_val`, go to SETUP.
  - `req_value` may change after E0.
- SETUP: `aload_out` stays 0 for one full cycle so the value is stable before the pulse.
- SETUP→PULSE at E1: `aload_out`←1, counter←PULSE_CYCLES-1.
- PULSE: the counter decrements each edge.
  - When the counter is 0: `aload_out`←0, go to HOLD. Exactly PULSE_CYCLES cycles high.
- HOLD: `aload_val` is held one extra cycle after the falling edge of `aload_out`.
  - Next edge: go to IDLE, `done`←1 for one cycle.
- `aload_val` changes only in IDLE at accept, or under `arst`.
- The counter width is $clog2(PULSE_CYCLES+1). No wrap: the counter is reloaded on every SETUP→PULSE transition.
- `arst` asserted mid-sequence: abort immediately and re-enter RST_HOLD. No `done` is produced for the aborted request.
- `req_valid` while busy: ignored (not accepted). The upstream source must hold it until `req_ready`.

## Timing
- Accept edge E0. `aload_out` is high from E1 to E(1+P), where P=PULSE_CYCLES.
- Return to IDLE and `done` high in the cycle after E(2+P).
- Accept-to-`done` latency: P+2 cycles. `req_ready` re-asserts together with `done`.
- Back-to-back throughput: one load per P+3 cycles.
- `arst` deassertion to `req_ready`: SYNC_STAGES cycles.
- All outputs are registered. `aload_out` comes from a single flop with no combinational decode.

## Configuration
- `ALOAD_SEQ_VERIFY_EN` defined:
  - In HOLD, `q_in` is compared with `aload_val`.
  - The result is registered into `mismatch` at the same edge as `done`, pulse-aligned with `done`.
  - An internal 8-bit saturating mismatch counter is exposed as a hierarchical signal for debug.
  - Latency is unchanged.
- Macro undefined: `q_in` is unused, `mismatch` is constant 0, and no compare logic is built.

## Structure
- Package `aload_pkg`: state enum `aload_state_t` (RST_HOLD, IDLE, SETUP, PULSE, HOLD).
- Sub-module `aload_rst_sync`:
  - SYNC_STAGES-deep reset-release synchronizer.
  - Asserts asynchronously and deasserts synchronously.
  - Its output drives the RST_HOLD exit.

## Test plan
- **Reset release.** Hold `arst` for 5 cycles, then release (defaults). Expect:
  - `aload_out`=1 and `aload_val`=0x00 throughout reset.
  - `aload_out` falls and `req_ready` rises exactly 2 edges after release.
- **Single load.** Accept `req_value`=0xA5. Expect:
  - `aload_val`=0xA5 at E0.
  - `aload_out` high for exactly 2 cycles, starting at E1.
  - `done` 1-cycle pulse 4 cycles after accept; `aload_val` still 0xA5.
- **Back-to-back requests.** Keep `req_valid` high with 0x11 then 0x22. Expect:
  - Second accept only when `req_ready` returns.
  - Loads spaced 5 cycles apart; `aload_val` never changes during SETUP, PULSE or HOLD.
- **Reset mid-pulse.** Assert `arst` during PULSE with 0x3C loading. Expect:
  - `aload_val`=RESET_VALUE and `aload_out`=1 immediately.
  - No `done`; normal RST_HOLD recovery.
- **Wide pulse.** Set PULSE_CYCLES=1, then 7. Expect `aload_out` high for exactly 1 and 7 cycles, with latency 3 and 9 respectively.
- **Readback check (verify build).** With `ALOAD_SEQ_VERIFY_EN` defined, connect the emulated async-load FF bank as `q_in`. Expect:
  - Load 0x5A: `mismatch`=0.
  - Force a `q_in` bit flipped during HOLD: `mismatch`=1 coincident with `done`, and the counter increments to 1.

Source files
------------

// File: rtl/aload_pkg.sv
// Shared types for the async-load sequencer: FSM state encoding and counter sizing.
package aload_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } aload_state_t;

  // Pulse counter width; counts PULSE_CYCLES-1 down to 0.
  function automatic int cnt_width(input int pulse_cycles);
    return (pulse_cycles < 1) ? 1 : $clog2(pulse_cycles + 1);
  endfunction

endpackage

// File: rtl/aload_rst_sync.sv
// Reset-release synchronizer: asserts with arst, releases after STAGES clk edges.
module aload_rst_sync #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic arst,
  output logic rst_sync
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = sync_q << 1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_sync = sync_q[STAGES-1];

endmodule

// File: rtl/aload_sequencer.sv
// Turns clocked load requests into a set-up/pulse/hold async-load sequence for an async-load FF bank.
// Define ALOAD_SEQ_VERIFY_EN to build the bank readback compare and its mismatch counter.
module aload_sequencer
  import aload_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               PULSE_CYCLES = 2,
  parameter int               SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_value,
  output logic             aload_out,
  output logic [WIDTH-1:0] aload_val,
  output logic             busy,
  output logic             done,
  input  logic [WIDTH-1:0] q_in,
  output logic             mismatch
);

  localparam int               CNT_W    = cnt_width(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

  aload_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aload_out_q, aload_out_d;
  logic [WIDTH-1:0] aload_val_q, aload_val_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rst_sync;

  // The state register acts as the final synchronizer stage, so RST_HOLD
  // exits on exactly the SYNC_STAGES-th edge after arst falls.
  aload_rst_sync #(
    .STAGES (SYNC_STAGES - 1)
  ) u_rst_sync (
    .clk      (clk),
    .arst     (arst),
    .rst_sync (rst_sync)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aload_out_d = aload_out_q;
    aload_val_d = aload_val_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      RST_HOLD: begin
        if (!rst_sync) begin
          state_d     = IDLE;
          aload_out_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      IDLE: begin
        if (req_valid && req_ready_q) begin
          aload_val_d = req_value;
          state_d     = SETUP;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      SETUP: begin
        state_d     = PULSE;
        aload_out_d = 1'b1;
        cnt_d       = CNT_LOAD;
      end
      PULSE: begin
        if (cnt_q == '0) begin
          aload_out_d = 1'b0;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        state_d     = IDLE;
        done_d      = 1'b1;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = RST_HOLD;
        aload_out_d = 1'b1;
        aload_val_d = RESET_VALUE;
        req_ready_d = 1'b0;
        busy_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= RST_HOLD;
      cnt_q       <= '0;
      aload_out_q <= 1'b1;
      aload_val_q <= RESET_VALUE;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aload_out_q <= aload_out_d;
      aload_val_q <= aload_val_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign aload_out = aload_out_q;
  assign aload_val = aload_val_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef ALOAD_SEQ_VERIFY_EN
  logic       mismatch_q, mismatch_d;
  logic [7:0] mism_cnt_q, mism_cnt_d;

  // Bank output is compared during HOLD so the flag lands with done.
  always_comb begin
    mismatch_d = 1'b0;
    mism_cnt_d = mism_cnt_q;
    if (state_q == HOLD && q_in != aload_val_q) begin
      mismatch_d = 1'b1;
      if (mism_cnt_q != 8'hFF) begin
        mism_cnt_d = mism_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mismatch_q <= 1'b0;
      mism_cnt_q <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      mism_cnt_q <= mism_cnt_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign mismatch    = 1'b0;
`endif

endmodule
